// File: rtl/tmds_video_scheduler.sv
// Raster timing generator and pixel scheduler feeding the three TMDS channel encoders.
// Every encoder-facing output is registered one cycle behind the counter state it describes.
module tmds_video_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        de,
    output logic [1:0]  ctrl0,
    output logic [1:0]  ctrl1,
    output logic [1:0]  ctrl2,
    output logic [7:0]  d0,
    output logic [7:0]  d1,
    output logic [7:0]  d2,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic [15:0] hcount,
    output logic [15:0] vcount
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_timing
            $error("tmds_video_scheduler: H_TOTAL and V_TOTAL must not exceed 65535");
        end
    endgenerate

    localparam logic [15:0] C_H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] C_HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] C_HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] C_H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] C_V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] C_VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] C_VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] C_V_LAST = 16'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [15:0] r_hc;
    logic [15:0] r_vc;
    logic        r_de;
    logic [1:0]  r_ctrl0;
    logic [7:0]  r_d0;
    logic [7:0]  r_d1;
    logic [7:0]  r_d2;
    logic        r_frameStart;
    logic        r_underflow;
    logic [15:0] r_hcount;
    logic [15:0] r_vcount;

    logic w_running;
    logic w_active;
    logic w_hsync;
    logic w_vsync;
    logic w_hEnd;
    logic w_frameEnd;
    logic w_take;
    logic w_starve;

    assign w_running  = (r_state != IDLE);
    assign w_active   = w_running && (r_hc < C_H_ACT) && (r_vc < C_V_ACT);
    assign w_hsync    = w_running && (r_hc >= C_HS_BEG) && (r_hc < C_HS_END);
    assign w_vsync    = w_running && (r_vc >= C_VS_BEG) && (r_vc < C_VS_END);
    assign w_hEnd     = (r_hc == C_H_LAST);
    assign w_frameEnd = w_hEnd && (r_vc == C_V_LAST);
    assign w_take     = w_active && pix_valid;
    assign w_starve   = w_active && !pix_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // STOP only falls back to IDLE on the last cycle of a frame so a frame is never cut short.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (enable) w_stateNext = RUN;
            RUN:     if (!enable) w_stateNext = STOP;
            STOP: begin
                if (enable)          w_stateNext = RUN;
                else if (w_frameEnd) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hc <= 16'd0;
            r_vc <= 16'd0;
        end else if (r_state == IDLE) begin
            r_hc <= 16'd0;
            r_vc <= 16'd0;
        end else if (w_hEnd) begin
            r_hc <= 16'd0;
            r_vc <= w_frameEnd ? 16'd0 : r_vc + 16'd1;
        end else begin
            r_hc <= r_hc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_de         <= 1'b0;
            r_ctrl0      <= {~VS_POL, ~HS_POL};
            r_d0         <= 8'h00;
            r_d1         <= 8'h00;
            r_d2         <= 8'h00;
            r_frameStart <= 1'b0;
            r_hcount     <= 16'd0;
            r_vcount     <= 16'd0;
        end else begin
            r_de         <= w_active;
            r_ctrl0      <= {(w_vsync ? VS_POL : ~VS_POL), (w_hsync ? HS_POL : ~HS_POL)};
            r_d2         <= w_take ? pix_data[23:16] : 8'h00;
            r_d1         <= w_take ? pix_data[15:8]  : 8'h00;
            r_d0         <= w_take ? pix_data[7:0]   : 8'h00;
            r_frameStart <= w_running && (r_hc == 16'd0) && (r_vc == 16'd0);
            r_hcount     <= r_hc;
            r_vcount     <= r_vc;
        end
    end

    // A fresh starvation event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_underflow <= 1'b0;
        end else if (w_starve) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign pix_ready   = w_active;
    assign de          = r_de;
    assign ctrl0       = r_ctrl0;
    assign ctrl1       = 2'b00;
    assign ctrl2       = 2'b00;
    assign d0          = r_d0;
    assign d1          = r_d1;
    assign d2          = r_d2;
    assign frame_start = r_frameStart;
    assign underflow   = r_underflow;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;

endmodule

// File: tb/tb_tmds_video_scheduler.sv
// Randomised bench for tmds_video_scheduler on a 8x6 raster, checked against a frame-position model.
module tb_tmds_video_scheduler;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        de;
    logic [1:0]  ctrl0;
    logic [1:0]  ctrl1;
    logic [1:0]  ctrl2;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;
    logic [15:0] hcount;
    logic [15:0] vcount;

    int checks;
    int errors;

    tmds_video_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .de(de),
        .ctrl0(ctrl0),
        .ctrl1(ctrl1),
        .ctrl2(ctrl2),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .frame_start(frame_start),
        .underflow(underflow),
        .underflow_clr(underflow_clr),
        .hcount(hcount),
        .vcount(vcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the frame plus a run mode (0 idle, 1 running, 2 draining).
    int          pos;
    int          mode;
    logic        expDe;
    logic [1:0]  expCtrl0;
    logic [23:0] expRgb;
    logic        expFs;
    logic        expUf;
    int          expH;
    int          expV;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos = 0; mode = 0;
            expDe = 1'b0; expCtrl0 = 2'b11; expRgb = 24'h0;
            expFs = 1'b0; expUf = 1'b0; expH = 0; expV = 0;
        end else begin
            int  hc, vc;
            bit  act, hsOn, vsOn, lastPix;
            hc   = pos % HT;
            vc   = pos / HT;
            act  = (mode != 0) && (hc < HA) && (vc < VA);
            hsOn = (mode != 0) && (hc >= HA + HF) && (hc < HA + HF + HS);
            vsOn = (mode != 0) && (vc >= VA + VF) && (vc < VA + VF + VS);
            expDe    = act;
            expRgb   = (act && pix_valid) ? pix_data : 24'h0;
            expCtrl0 = {~vsOn, ~hsOn};
            expFs    = (mode != 0) && (pos == 0);
            expH     = hc;
            expV     = vc;
            if (act && !pix_valid) expUf = 1'b1;
            else if (underflow_clr) expUf = 1'b0;
            if (mode == 0) begin
                if (enable) mode = 1;
            end else begin
                lastPix = (pos == FRAME - 1);
                pos = (pos + 1) % FRAME;
                if (mode == 1 && !enable) mode = 2;
                else if (mode == 2) begin
                    if (enable) mode = 1;
                    else if (lastPix) mode = 0;
                end
            end
        end
    end

    function automatic logic expReady();
        return (mode != 0) && ((pos % HT) < HA) && ((pos / HT) < VA);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("pix_ready", 32'(pix_ready), 32'(expReady()));
        checkOutput("de", 32'(de), 32'(expDe));
        checkOutput("ctrl0", 32'(ctrl0), 32'(expCtrl0));
        checkOutput("ctrl1", 32'(ctrl1), 32'h0);
        checkOutput("ctrl2", 32'(ctrl2), 32'h0);
        checkOutput("d2", 32'(d2), 32'(expRgb[23:16]));
        checkOutput("d1", 32'(d1), 32'(expRgb[15:8]));
        checkOutput("d0", 32'(d0), 32'(expRgb[7:0]));
        checkOutput("frame_start", 32'(frame_start), 32'(expFs));
        checkOutput("underflow", 32'(underflow), 32'(expUf));
        checkOutput("hcount", 32'(hcount), 32'(expH));
        checkOutput("vcount", 32'(vcount), 32'(expV));
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [23:0] data, input logic clr);
        enable        = en;
        pix_valid     = valid;
        pix_data      = data;
        underflow_clr = clr;
    endtask

    initial begin
        int found;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        #3;
        checkAll();
        @(negedge clk);
        resetn = 1'b1;

        // Steady stream of one colour, with one starved pixel and a later clear.
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            checkAll();
            applyStimulus(1'b1, (i != 60), 24'hA1B2C3, (i == 75));
        end

        // Random enable drops, starvation, data and clears.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checkAll();
            applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) != 0),
                          24'($urandom), ($urandom_range(0, 19) == 0));
        end

        // Drain to idle, then stay idle.
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            @(negedge clk);
            checkAll();
            applyStimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
        end

        // Restart, then hit reset asynchronously while an active pixel is on the outputs.
        found = 0;
        for (int i = 0; i < 3 * FRAME && found == 0; i++) begin
            @(negedge clk);
            checkAll();
            if (expDe && expH == 2 && expV == 0 && i > FRAME) found = 1;
            else applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
        end
        checkOutput("reset_point_reached", 32'(found), 32'd1);
        resetn = 1'b0;
        #1;
        checkAll();
        checkOutput("async_de", 32'(de), 32'd0);
        checkOutput("async_ctrl0", 32'(ctrl0), 32'h3);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            checkAll();
            applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
